// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with halt/drain FSM and perf counters.
// Latency: all control outputs combinational in the same cycle; FSM state and counters update on clk.
// Backpressure: stalls IF/ID on load-use (one cycle), flushes on redirects, freezes PC while draining/halted.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       FD_RS,
  input  logic [4:0]       FD_RT,
  input  logic             FD_use_rt,
  input  logic [4:0]       DX_RS,
  input  logic [4:0]       DX_RT,
  input  logic [4:0]       DX_RD,
  input  logic             DX_MemRead,
  input  logic             DX_jump,
  input  logic [4:0]       XM_RD,
  input  logic             XM_RegWrite,
  input  logic             XM_branch,
  input  logic [4:0]       MW_RD,
  input  logic             MW_RegWrite,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             fd_write,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [2:0] DCNT_LAST = 3'(DRAIN_CYC - 1);

  state_t     state, state_nxt;
  logic [2:0] dcnt, dcnt_nxt;
  logic       load_use;
  logic       redirect;
  logic       run;
  logic       stall_inc;

  // Operand source for one EX operand: MEM result beats WB result; r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (XM_RegWrite && (XM_RD != 5'd0) && (XM_RD == src))
      return 2'b10;
    else if (MW_RegWrite && (MW_RD != 5'd0) && (MW_RD == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use = DX_MemRead && (DX_RD != 5'd0) &&
                    ((DX_RD == FD_RS) || (FD_use_rt && (DX_RD == FD_RT)));
  assign redirect  = XM_branch || DX_jump;
  assign run       = (state == RUN);
  assign stall_inc = run && load_use && !redirect;
  assign halted    = (state == HALTED);

  // State register and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      dcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next state: drain always runs to completion once entered.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      RUN: begin
        if (halt_req) begin
          state_nxt = DRAIN;
          dcnt_nxt  = 3'd0;
        end
      end
      DRAIN: begin
        if (dcnt == DCNT_LAST) state_nxt = HALTED;
        else                   dcnt_nxt  = dcnt + 3'd1;
      end
      HALTED: begin
        if (!halt_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Pipeline control: branch > jump > load-use > normal, then drain/halt override, then reset values.
  always_comb begin
    pc_write = 1'b1;
    pc_sel   = 2'b00;
    fd_write = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    xm_flush = 1'b0;
    fwd_a    = fwd_sel(DX_RS);
    fwd_b    = fwd_sel(DX_RT);
    if (XM_branch) begin
      pc_sel   = 2'b01;
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      xm_flush = 1'b1;
    end else if (DX_jump) begin
      pc_sel   = 2'b10;
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (load_use && run) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_flush = 1'b1;
    end
    // While draining or halted, fetch is discarded but redirects still steer the resume PC.
    if (!run) begin
      fd_flush = 1'b1;
      fd_write = 1'b1;
      if (!redirect) pc_write = 1'b0;
    end
    if (!rst) begin
      pc_write = 1'b0;
      pc_sel   = 2'b00;
      fd_write = 1'b0;
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      xm_flush = 1'b1;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
